// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group per stage, WIDTH+1-bit signed result.
// Optional feature: define CLA_PIPE_SAT_EN to add the registered saturating SatSum output.
module cla_pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   Sum,
  output logic             Ovf
`ifdef CLA_PIPE_SAT_EN
  ,
  output logic [WIDTH-1:0] SatSum
`endif
);
  localparam int NSTG = WIDTH / GROUP;

  logic                       en;
  logic [NSTG-1:0]            st_valid;
  logic [NSTG-1:0]            st_c;
  logic [NSTG-1:0]            nx_c;
  logic [NSTG-1:0][WIDTH-1:0] st_a;
  logic [NSTG-1:0][WIDTH-1:0] st_b;
  logic [NSTG-1:0][WIDTH-1:0] st_sum;
  logic [NSTG-1:0][WIDTH-1:0] nx_sum;
  logic                       msb_c;
  logic                       msb_p;
  logic [WIDTH:0]             fin_sum;
  logic                       fin_ovf;
  logic                       unused_bits;

  // One global stall: the whole pipe freezes while a result waits downstream.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar s = 0; s < NSTG; s++) begin : g_stage
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   cv;
    logic [WIDTH-1:0] ssum;
    logic             c;
    logic             t;

    // Every carry is a flat sum of products of p/g and the registered group carry-in.
    always_comb begin
      p     = st_a[s][s*GROUP +: GROUP] ^ st_b[s][s*GROUP +: GROUP];
      g     = st_a[s][s*GROUP +: GROUP] & st_b[s][s*GROUP +: GROUP];
      cv    = '0;
      c     = 1'b0;
      t     = 1'b0;
      cv[0] = st_c[s];
      for (int i = 0; i < GROUP; i++) begin
        c = st_c[s];
        for (int k = 0; k <= i; k++) c = c & p[k];
        for (int j = 0; j <= i; j++) begin
          t = g[j];
          for (int k = j + 1; k <= i; k++) t = t & p[k];
          c = c | t;
        end
        cv[i+1] = c;
      end
      ssum = st_sum[s];
      ssum[s*GROUP +: GROUP] = p ^ cv[GROUP-1:0];
    end

    assign nx_sum[s] = ssum;
    assign nx_c[s]   = cv[GROUP];

    if (s == NSTG - 1) begin : g_last
      assign msb_c = cv[GROUP-1];
      assign msb_p = p[GROUP-1];
    end
  end

  assign fin_sum = {msb_p ^ nx_c[NSTG-1], nx_sum[NSTG-1]};
  assign fin_ovf = nx_c[NSTG-1] ^ msb_c;

  // Consumed low operand bits of the last stage are intentionally dropped.
  assign unused_bits = ^{st_a[NSTG-1], st_b[NSTG-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid  <= '0;
      st_c      <= '0;
      st_a      <= '0;
      st_b      <= '0;
      st_sum    <= '0;
      out_valid <= 1'b0;
      Sum       <= '0;
      Ovf       <= 1'b0;
    end else if (en) begin
      st_valid[0] <= in_valid;
      st_sum[0]   <= '0;
      if (in_valid) begin
        st_a[0] <= A;
        st_b[0] <= Sub ? ~B : B;
        st_c[0] <= Sub;
      end
      for (int s = 1; s < NSTG; s++) begin
        st_valid[s] <= st_valid[s-1];
        st_a[s]     <= st_a[s-1];
        st_b[s]     <= st_b[s-1];
        st_sum[s]   <= nx_sum[s-1];
        st_c[s]     <= nx_c[s-1];
      end
      out_valid <= st_valid[NSTG-1];
      Sum       <= fin_sum;
      Ovf       <= fin_ovf;
    end
  end

`ifdef CLA_PIPE_SAT_EN
  logic [WIDTH-1:0] fin_sat;

  // Clamp towards the true sign whenever the WIDTH-bit result wrapped.
  always_comb begin
    fin_sat = fin_sum[WIDTH-1:0];
    if (fin_ovf)
      fin_sat = fin_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      SatSum <= '0;
    else if (en)
      SatSum <= fin_sat;
  end
`endif

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench for cla_pipe_addsub (WIDTH=16, GROUP=4): directed steps plus a queue scoreboard.
// Checks SatSum too when compiled with CLA_PIPE_SAT_EN.
module tb_cla_pipe_addsub;
  localparam int W  = 16;
  localparam int G  = 4;
  localparam int NS = W / G;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         sub_in;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum_out;
  logic         ovf_out;
`ifdef CLA_PIPE_SAT_EN
  logic [W-1:0] sat_out;
`endif

  typedef struct packed {
    logic [W:0]   sum;
    logic         ovf;
    logic [W-1:0] sat;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  int           beat;
  int           accepted;
  logic         hold_pending = 1'b0;
  logic [W:0]   held_sum;
  logic         held_ovf;

  cla_pipe_addsub #(.WIDTH(W), .GROUP(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_in),
    .B         (b_in),
    .Sub       (sub_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (sum_out),
    .Ovf       (ovf_out)
`ifdef CLA_PIPE_SAT_EN
    ,
    .SatSum    (sat_out)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W+1:0] ea;
    logic [W+1:0] eb;
    logic [W+1:0] r;
    exp_t         e;
    ea    = {{2{a[W-1]}}, a};
    eb    = {{2{b[W-1]}}, b};
    r     = sub ? (ea - eb) : (ea + eb);
    e.sum = r[W:0];
    e.ovf = r[W] ^ r[W-1];
    if (e.ovf)
      e.sat = r[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      e.sat = r[W-1:0];
    return e;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] corners [4];
    corners[0] = {1'b0, {(W-1){1'b1}}};
    corners[1] = {1'b1, {(W-1){1'b0}}};
    corners[2] = '1;
    corners[3] = '0;
    if ($urandom_range(0, 5) == 0)
      return corners[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic valid);
    a_in     = a;
    b_in     = b;
    sub_in   = sub;
    in_valid = valid;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Handshakes are observed mid-cycle; both transfers happen at the following rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        checkOutput("hold_valid", 64'(out_valid), 64'(1'b1));
        checkOutput("hold_sum", 64'(sum_out), 64'(held_sum));
        checkOutput("hold_ovf", 64'(ovf_out), 64'(held_ovf));
      end
      if (out_valid && out_ready) begin
        checkOutput("sb_nonempty", 64'(sb.size() != 0), 64'(1'b1));
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          checkOutput("sb_sum", 64'(sum_out), 64'(mon_e.sum));
          checkOutput("sb_ovf", 64'(ovf_out), 64'(mon_e.ovf));
`ifdef CLA_PIPE_SAT_EN
          checkOutput("sb_sat", 64'(sat_out), 64'(mon_e.sat));
`endif
        end
      end
      hold_pending = out_valid && !out_ready;
      held_sum     = sum_out;
      held_ovf     = ovf_out;
      if (in_valid && in_ready)
        sb.push_back(model(a_in, b_in, sub_in));
    end
  end

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    applyStimulus('0, '0, 1'b0, 1'b0);
    repeat (2) cycle();
    checkOutput("rst_out_valid", 64'(out_valid), 64'(1'b0));
    checkOutput("rst_sum", 64'(sum_out), 64'(0));
    checkOutput("rst_ovf", 64'(ovf_out), 64'(1'b0));
`ifdef CLA_PIPE_SAT_EN
    checkOutput("rst_sat", 64'(sat_out), 64'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    checkOutput("in_ready_after_reset", 64'(in_ready), 64'(1'b1));

    // Positive overflow and exact latency.
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    cycle();
    applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("lat_valid_0", 64'(out_valid), 64'(1'b0));
    for (int i = 1; i <= NS; i++) begin
      cycle();
      checkOutput($sformatf("lat_valid_%0d", i), 64'(out_valid), 64'(i == NS));
    end
    checkOutput("t1_sum", 64'(sum_out), 64'(17'h08000));
    checkOutput("t1_ovf", 64'(ovf_out), 64'(1'b1));
`ifdef CLA_PIPE_SAT_EN
    checkOutput("t1_sat", 64'(sat_out), 64'(16'h7FFF));
`endif

    // 0 - 1 = -1.
    applyStimulus(16'h0000, 16'h0001, 1'b1, 1'b1);
    cycle();
    applyStimulus('0, '0, 1'b0, 1'b0);
    repeat (NS) cycle();
    checkOutput("t2_valid", 64'(out_valid), 64'(1'b1));
    checkOutput("t2_sum", 64'(sum_out), 64'(17'h1FFFF));
    checkOutput("t2_ovf", 64'(ovf_out), 64'(1'b0));
`ifdef CLA_PIPE_SAT_EN
    checkOutput("t2_sat", 64'(sat_out), 64'(16'hFFFF));
`endif

    // Negative overflow: -32768 - 1.
    applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b1);
    cycle();
    applyStimulus('0, '0, 1'b0, 1'b0);
    repeat (NS) cycle();
    checkOutput("t3_valid", 64'(out_valid), 64'(1'b1));
    checkOutput("t3_sum", 64'(sum_out), 64'(17'h17FFF));
    checkOutput("t3_ovf", 64'(ovf_out), 64'(1'b1));
`ifdef CLA_PIPE_SAT_EN
    checkOutput("t3_sat", 64'(sat_out), 64'(16'h8000));
`endif
    cycle();

    // Eight back-to-back beats with a three-cycle downstream stall.
    beat = 0;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 6 && c <= 8);
      if (beat < 8)
        applyStimulus(W'(beat), W'(16'h1000 * beat), 1'b0, 1'b1);
      else
        applyStimulus('0, '0, 1'b0, 1'b0);
      #1;
      if (c < 11)
        checkOutput($sformatf("stall_in_ready_c%0d", c), 64'(in_ready), 64'(!(c >= 6 && c <= 8)));
      if (in_valid && in_ready)
        beat++;
      cycle();
    end
    checkOutput("stall_beats_sent", 64'(beat), 64'(8));
    checkOutput("stall_drained", 64'(sb.size()), 64'(0));

    // Reset in the middle of a full pipe.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(pick_operand(), pick_operand(), $urandom_range(0, 1) != 0, 1'b1);
      cycle();
    end
    applyStimulus('0, '0, 1'b0, 1'b0);
    cycle();
    checkOutput("pre_reset_valid", 64'(out_valid), 64'(1'b1));
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'(1'b0));
    checkOutput("mid_rst_sum", 64'(sum_out), 64'(0));
    checkOutput("mid_rst_ovf", 64'(ovf_out), 64'(1'b0));
    cycle();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'(1'b1));
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("post_rst_idle_%0d", i), 64'(out_valid), 64'(1'b0));
      cycle();
    end

    // Random traffic with random backpressure; the scoreboard checks every result.
    accepted = 0;
    for (int c = 0; c < 20000 && accepted < 2000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      applyStimulus(pick_operand(), pick_operand(), $urandom_range(0, 1) != 0,
                    $urandom_range(0, 1) != 0);
      #1;
      if (in_valid && in_ready)
        accepted++;
      cycle();
    end
    checkOutput("rand_accepted", 64'(accepted), 64'(2000));
    applyStimulus('0, '0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int c = 0; c < 50 && sb.size() != 0; c++)
      cycle();
    checkOutput("final_drain", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor, the multi-width successor to the team's 8-bit combinational CLA. Operands are split into GROUP-bit lookahead groups. Each group is resolved in its own pipeline stage, and the group carry is registered between stages. Sits in datapaths needing WIDTH-bit signed add/sub at full clock rate, with valid/ready flow control on both sides and a sign-extended WIDTH+1-bit result.

## Interface
Parameters:
- WIDTH, 16, operand width.
  - Must be a multiple of GROUP; legal range 4..64.
- GROUP, 4, bits per lookahead group and pipeline stage.
  - Legal range 2..8.
- NSTG, WIDTH/GROUP, number of stages (derived localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- A  in  WIDTH  operand A, two's complement.
- B  in  WIDTH  operand B, two's complement.
- Sub  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- Sum  out  WIDTH+1  signed result, sign-extended, never overflows.
- Ovf  out  1  the WIDTH-bit truncation of Sum overflowed.
- SatSum  out  WIDTH  saturated WIDTH-bit result (present only with CLA_PIPE_SAT_EN).

## Operation
- Subtraction:
  - B is bitwise inverted (B').
  - Group-0 carry-in is Sub.
- Stage s (0..NSTG−1) processes bits [s·GROUP +: GROUP]:
  - p = a^b', g = a&b'.
  - Each carry within the group is a full lookahead expression of group p/g and the registered group carry-in; no ripple inside the group.
  - Sum bits = p ^ carry.
- Stage register contents:
  - valid bit.
  - Sum bits produced so far.
  - Unconsumed upper A/B'/Sub slices, skewed forward.
  - Group carry-out.
  - Carry into the MSB (needed for Ovf).
- Final result:
  - Sum[WIDTH] = A[W−1] ^ B'[W−1] ^ C[WIDTH], the sign extension.
  - Ovf = C[WIDTH] ^ C[WIDTH−1].
- Flow control uses a global stall: en = !out_valid | out_ready.
  - in_ready = en.
  - A beat is accepted when in_valid & en.
  - All stages advance only when en.
  - Bubbles are not collapsed.
- Results leave in acceptance order. No beat is dropped or duplicated.
- Sum/Ovf/SatSum stay stable while out_valid & !out_ready.

## Timing
- Latency: an input accepted at edge k presents out_valid with its result after edge k+NSTG, provided no stall occurs in between.
- Throughput: one beat per cycle while out_ready is high.
- Stall: each cycle with out_valid & !out_ready extends latency by one cycle for every in-flight beat.
- in_ready is combinational from out_valid and out_ready only. It never depends on in_valid.
- Simultaneous output pop and input accept in the same cycle is legal and is the steady state.
- Reset (asynchronous assert, synchronous-to-clk deassert by the system):
  - All stage valids = 0.
  - out_valid = 0, Sum = 0, Ovf = 0, SatSum = 0.
  - in_ready = 1 on the first cycle after deassertion.
- Reset mid-stream discards all in-flight beats. No partial result appears afterwards.
- Bubble stages hold X-free data. Their data registers may keep stale values, but out_valid is the sole qualifier.

## Configuration
- CLA_PIPE_SAT_EN defined:
  - SatSum port exists.
  - SatSum = 2^(W−1)−1 if Ovf & !Sum[WIDTH].
  - SatSum = −2^(W−1) if Ovf & Sum[WIDTH].
  - Otherwise SatSum = Sum[W−1:0].
  - Registered with the final stage, so latency is unchanged.
- CLA_PIPE_SAT_EN undefined: SatSum port and clamp logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=16, GROUP=4, Sub=0, A=0x7FFF, B=0x0001, out_ready=1:
  - out_valid exactly 4 cycles later.
  - Sum=0x08000, Ovf=1, SatSum=0x7FFF.
- Sub=1, A=0x0000, B=0x0001:
  - Sum=0x1FFFF (−1), Ovf=0, SatSum=0xFFFF.
- Sub=1, A=0x8000, B=0x0001:
  - Sum=0x17FFF (−32769), Ovf=1, SatSum=0x8000.
- 8 back-to-back beats with A=i, B=0x1000·i; out_ready low for 3 cycles starting at cycle 6:
  - in_ready low for exactly those 3 cycles.
  - 8 results in order, each Sum=0x1001·i.
  - Result held stable during the stall.
- Fill the pipe with 4 beats, then assert rst_n=0 for 1 cycle:
  - out_valid=0 and Sum=0 immediately.
  - No stale result emerges during the following 8 idle cycles.
- Random regression, WIDTH∈{8,16,32}, GROUP∈{2,4,8}, random in_valid and out_ready, 10k beats:
  - Scoreboard checks Sum = sign-extended A±B and Ovf against a reference model.
  - Checks ordering and no loss.
